// File: rtl/ripple_count_reader_if.sv
// Result channel of the ripple counter reader: coherent count plus delta/wrap/error flags,
// transferred with a valid/ready handshake.
interface ripple_count_reader_if #(
  parameter int unsigned WIDTH = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_count;
  logic [WIDTH-1:0] out_delta;
  logic             out_wrap;
  logic             out_err;

  modport master (
    output out_valid,
    output out_count,
    output out_delta,
    output out_wrap,
    output out_err,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_count,
    input  out_delta,
    input  out_wrap,
    input  out_err,
    output out_ready
  );
endinterface

// File: rtl/ripple_count_reader.sv
// Reads the skewed, asynchronous bits of a ripple counter into the clk domain on request,
// resampling until two consecutive synchronized samples agree.
module ripple_count_reader #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_TRIES   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 sample_req,
  output logic                 busy,
  ripple_count_reader_if.master res
);

  localparam int unsigned TryW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TryW-1:0] LastTry = TryW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StHold
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] sync_flops_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;

  logic [WIDTH-1:0] a_reg_q, a_reg_d;
  logic [TryW-1:0]  tries_q, tries_d;
  logic [WIDTH-1:0] prev_count_q, prev_count_d;
  logic [WIDTH-1:0] out_count_q, out_count_d;
  logic [WIDTH-1:0] out_delta_q, out_delta_d;
  logic             out_wrap_q, out_wrap_d;
  logic             out_err_q, out_err_d;

  // Per-bit synchronizer; bits may resolve in different cycles, hence the compare loop below.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_flops_q[i] <= '0;
      end
    end else begin
      sync_flops_q[0] <= count_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_flops_q[i] <= sync_flops_q[i-1];
      end
    end
  end

  assign sync_q = sync_flops_q[SYNC_STAGES-1];

  always_comb begin
    state_d      = state_q;
    a_reg_d      = a_reg_q;
    tries_d      = tries_q;
    prev_count_d = prev_count_q;
    out_count_d  = out_count_q;
    out_delta_d  = out_delta_q;
    out_wrap_d   = out_wrap_q;
    out_err_d    = out_err_q;

    unique case (state_q)
      StIdle: begin
        if (sample_req) begin
          a_reg_d = sync_q;
          tries_d = '0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        // On the last try the latest sample is returned anyway, flagged as unsettled.
        if ((sync_q == a_reg_q) || (tries_q == LastTry)) begin
          out_count_d = sync_q;
          out_delta_d = sync_q - prev_count_q;
          out_wrap_d  = (sync_q < prev_count_q);
          out_err_d   = (sync_q != a_reg_q);
          state_d     = StHold;
        end else begin
          a_reg_d = sync_q;
          tries_d = tries_q + TryW'(1);
        end
      end
      StHold: begin
        if (res.out_ready) begin
          prev_count_d = out_count_q;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      a_reg_q      <= '0;
      tries_q      <= '0;
      prev_count_q <= '0;
      out_count_q  <= '0;
      out_delta_q  <= '0;
      out_wrap_q   <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_reg_q      <= a_reg_d;
      tries_q      <= tries_d;
      prev_count_q <= prev_count_d;
      out_count_q  <= out_count_d;
      out_delta_q  <= out_delta_d;
      out_wrap_q   <= out_wrap_d;
      out_err_q    <= out_err_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign res.out_valid = (state_q == StHold);
  assign res.out_count = out_count_q;
  assign res.out_delta = out_delta_q;
  assign res.out_wrap  = out_wrap_q;
  assign res.out_err   = out_err_q;

endmodule

// File: tb/tb_ripple_count_reader.sv
// Directed bench for ripple_count_reader: table of stable reads plus hand-written sequences
// for unsettled input, backpressure and reset during a compare.
module tb_ripple_count_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] count_in;
  logic       sample_req;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  ripple_count_reader_if #(.WIDTH(8)) res ();

  ripple_count_reader #(
    .WIDTH      (8),
    .SYNC_STAGES(2),
    .MAX_TRIES  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .sample_req(sample_req),
    .busy      (busy),
    .res       (res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cnt;
    logic [7:0] delta;
    logic       wrap;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] c, input logic [7:0] d,
                              input logic w, input logic e);
    chk({tag, ".valid"}, 32'(res.out_valid), 32'(1'b1));
    chk({tag, ".count"}, 32'(res.out_count), 32'(c));
    chk({tag, ".delta"}, 32'(res.out_delta), 32'(d));
    chk({tag, ".wrap"},  32'(res.out_wrap),  32'(w));
    chk({tag, ".err"},   32'(res.out_err),   32'(e));
  endtask

  // Stable input: result must appear exactly one cycle after the request is accepted.
  task automatic stable_read(input string tag, input logic [7:0] v, input logic [7:0] d,
                             input logic w);
    count_in = v;
    repeat (3) tick();
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    chk({tag, ".busy_acc"},  32'(busy), 32'(1'b1));
    chk({tag, ".valid_acc"}, 32'(res.out_valid), 32'(1'b0));
    tick();
    check_result(tag, v, d, w, 1'b0);
    res.out_ready = 1'b1;
    tick();
    res.out_ready = 1'b0;
    chk({tag, ".valid_done"}, 32'(res.out_valid), 32'(1'b0));
    chk({tag, ".busy_done"},  32'(busy), 32'(1'b0));
  endtask

  initial begin
    rst           = 1'b1;
    count_in      = 8'hFF;
    sample_req    = 1'b0;
    res.out_ready = 1'b0;
    repeat (2) tick();
    chk("rst.busy",  32'(busy), 32'(1'b0));
    chk("rst.valid", 32'(res.out_valid), 32'(1'b0));
    chk("rst.count", 32'(res.out_count), 32'(8'h00));
    chk("rst.delta", 32'(res.out_delta), 32'(8'h00));
    chk("rst.wrap",  32'(res.out_wrap), 32'(1'b0));
    chk("rst.err",   32'(res.out_err), 32'(1'b0));
    rst = 1'b0;

    vecs[0] = '{cnt: 8'h2A, delta: 8'h2A, wrap: 1'b0};
    vecs[1] = '{cnt: 8'h35, delta: 8'h0B, wrap: 1'b0};
    vecs[2] = '{cnt: 8'hF0, delta: 8'hBB, wrap: 1'b0};
    vecs[3] = '{cnt: 8'h10, delta: 8'h20, wrap: 1'b1};
    vecs[4] = '{cnt: 8'h10, delta: 8'h00, wrap: 1'b0};
    vecs[5] = '{cnt: 8'hFF, delta: 8'hEF, wrap: 1'b0};
    vecs[6] = '{cnt: 8'h00, delta: 8'h01, wrap: 1'b1};
    for (int i = 0; i < 7; i++) begin
      stable_read($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].delta, vecs[i].wrap);
    end

    // Input changes every cycle: accepted at edge 3, gives up at edge 7 with the sample
    // that entered the synchronizer at edge 5 (0x65).
    for (int i = 0; i < 10; i++) begin
      count_in   = 8'h60 + 8'(i);
      sample_req = (i == 3);
      tick();
      if (i >= 3 && i <= 6) begin
        chk($sformatf("unst.valid_%0d", i), 32'(res.out_valid), 32'(1'b0));
        chk($sformatf("unst.busy_%0d", i),  32'(busy), 32'(1'b1));
      end else if (i >= 7) begin
        check_result($sformatf("unst%0d", i), 8'h65, 8'h65, 1'b0, 1'b1);
      end
    end
    sample_req    = 1'b0;
    res.out_ready = 1'b1;
    tick();
    res.out_ready = 1'b0;
    chk("unst.valid_done", 32'(res.out_valid), 32'(1'b0));
    stable_read("after_err", 8'h05, 8'hA0, 1'b1);

    // Backpressure with a request during HOLD and another in the handshake cycle.
    count_in = 8'h77;
    repeat (3) tick();
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    tick();
    check_result("bp", 8'h77, 8'h72, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      count_in   = 8'h10 + 8'(k);
      sample_req = (k == 2);
      tick();
      check_result($sformatf("bp_hold%0d", k), 8'h77, 8'h72, 1'b0, 1'b0);
    end
    res.out_ready = 1'b1;
    sample_req    = 1'b1;
    tick();
    res.out_ready = 1'b0;
    sample_req    = 1'b0;
    chk("bp.valid_done", 32'(res.out_valid), 32'(1'b0));
    chk("bp.busy_done",  32'(busy), 32'(1'b0));
    repeat (2) tick();
    chk("bp.ignored_busy",  32'(busy), 32'(1'b0));
    chk("bp.ignored_valid", 32'(res.out_valid), 32'(1'b0));

    // Reset while comparing an unsettled input.
    for (int i = 0; i < 5; i++) begin
      count_in   = 8'h80 + 8'(i);
      sample_req = (i == 2);
      rst        = (i == 4);
      tick();
      if (i == 3) chk("rstmid.busy_pre", 32'(busy), 32'(1'b1));
    end
    rst        = 1'b0;
    sample_req = 1'b0;
    chk("rstmid.busy",  32'(busy), 32'(1'b0));
    chk("rstmid.valid", 32'(res.out_valid), 32'(1'b0));
    chk("rstmid.count", 32'(res.out_count), 32'(8'h00));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rstmid.novalid%0d", i), 32'(res.out_valid), 32'(1'b0));
    end
    stable_read("post_rst", 8'h33, 8'h33, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
